// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one generic pipeline boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Moves a control field and a data field through a valid/ready handshake, with flush.
// Control bits are zeroed whenever the stage holds a bubble. Data bits keep their last
// loaded value and are cleared only by reset.
// Optional feature macro: PIPE_SKID_EN adds a skid register S. With S present, in_ready
// is a pure register output and the stage holds two entries. Without the macro, in_ready
// is combinational from out_ready and the stage holds one entry.
module pipe_stage_reg #(
   parameter int CTRL_W = 8,
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   // The stall counter stops at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic              mVld_p1;
   logic [CTRL_W-1:0] mCtrl_p1;
   logic [DATA_W-1:0] mData_p1;
   logic [CNT_W-1:0]  stallCnt_p1;

   logic inFire;
   logic outFire;
   logic mLoad;

   assign outFire = mVld_p1 & out_ready;
   assign inFire  = in_valid & in_ready;
   // M may take a new entry when it is empty or its entry leaves this cycle.
   assign mLoad   = !mVld_p1 | outFire;

`ifdef PIPE_SKID_EN
   logic              sVld_p1;
   logic [CTRL_W-1:0] sCtrl_p1;
   logic [DATA_W-1:0] sData_p1;

   // Ready depends only on the skid register, so no path runs back from out_ready.
   assign in_ready = !sVld_p1;

   // M and S update: reset over flush over load; S refills M before new input does.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mVld_p1  <= 1'b0;
         mCtrl_p1 <= '0;
         mData_p1 <= '0;
         sVld_p1  <= 1'b0;
         sCtrl_p1 <= '0;
         sData_p1 <= '0;
      end else if (flush) begin
         mVld_p1  <= 1'b0;
         mCtrl_p1 <= '0;
         sVld_p1  <= 1'b0;
         sCtrl_p1 <= '0;
      end else if (mLoad) begin
         if (sVld_p1) begin
            mVld_p1  <= 1'b1;
            mCtrl_p1 <= sCtrl_p1;
            mData_p1 <= sData_p1;
            sVld_p1  <= 1'b0;
            sCtrl_p1 <= '0;
         end else if (inFire) begin
            mVld_p1  <= 1'b1;
            mCtrl_p1 <= in_ctrl;
            mData_p1 <= in_data;
         end else begin
            mVld_p1  <= 1'b0;
            mCtrl_p1 <= '0;
         end
      end else if (inFire) begin
         // M is full and stalled: the entry accepted this cycle parks in S.
         sVld_p1  <= 1'b1;
         sCtrl_p1 <= in_ctrl;
         sData_p1 <= in_data;
      end
   end
`else
   // Without skid storage, ready must see out_ready in the same cycle.
   assign in_ready = !mVld_p1 | out_ready;

   // M update: reset over flush over load; an empty load leaves a bubble.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mVld_p1  <= 1'b0;
         mCtrl_p1 <= '0;
         mData_p1 <= '0;
      end else if (flush) begin
         mVld_p1  <= 1'b0;
         mCtrl_p1 <= '0;
      end else if (mLoad) begin
         if (inFire) begin
            mVld_p1  <= 1'b1;
            mCtrl_p1 <= in_ctrl;
            mData_p1 <= in_data;
         end else begin
            mVld_p1  <= 1'b0;
            mCtrl_p1 <= '0;
         end
      end
   end
`endif

   // Count cycles where a valid entry is held back; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stallCnt_p1 <= '0;
      end else if (mVld_p1 && !out_ready) begin
         stallCnt_p1 <= satInc(stallCnt_p1);
      end
   end

   assign out_valid = mVld_p1;
   assign out_ctrl  = mCtrl_p1;
   assign out_data  = mData_p1;
   assign stall_cnt = stallCnt_p1;

endmodule
